// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package reg_file_sb_pkg;
  localparam int          DATA_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 5;
  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        READ_ENABLE  = 1'b1;
endpackage

// File: rtl/reg_file_sb_counter.sv
// Saturating up/down in-flight counter for one register.
// A decrement only takes effect while the count is non-zero.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nz
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign nz = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      case ({inc, dec && nz})
        2'b10:   if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-to-read bypass and a per-register
// pending-write scoreboard used by decode to raise hazard stalls.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int CNT_W    = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic                     stall,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  input  logic                     flush,
  output logic                     err
);
  localparam int               DEPTH   = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt  [DEPTH];
  logic [DEPTH-1:0]  nz, inc, dec;
  logic              w_live, iss_fire;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Issue handshake: an issue is accepted only in a cycle where
  // iss_valid && iss_ready; while iss_ready is low ID holds iss_addr.
  assign w_live    = (we == WRITE_ENABLE) && !is_zero(waddr);
  assign iss_ready = !rst && ((cnt[iss_addr] != CNT_MAX) || (we && (waddr == iss_addr)));
  assign iss_fire  = iss_valid && iss_ready && !is_zero(iss_addr);

  for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
    assign inc[g] = iss_fire && (iss_addr == ADDR_W'(g));
    assign dec[g] = w_live && (waddr == ADDR_W'(g));
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc[g]),
      .dec (dec[g]),
      .clr (flush),
      .cnt (cnt[g]),
      .nz  (nz[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (w_live) begin
      regs[waddr] <= wdata;
    end
  end

  // Flush does not mask the orphan check: the write itself still happens.
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (w_live && !nz[waddr]) err <= 1'b1;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] rd;

    assign ra  = raddr[p*ADDR_W +: ADDR_W];
    assign hit = we && (waddr == ra);

    always_comb begin
      rd = '0;
      if (!rst && (re[p] == READ_ENABLE) && !is_zero(ra)) rd = hit ? wdata : regs[ra];
    end

    // A pending write that retires this cycle is satisfied by the bypass.
    assign rbusy[p] = !rst && re[p] && nz[ra] && !(hit && (cnt[ra] == CNT_ONE));
    assign rdata[p*DATA_W +: DATA_W] = rd;
  end

  assign stall = |rbusy;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb with three read ports.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic [NR-1:0]  re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rbusy;
  logic           stall;
  logic           iss_valid;
  logic [AW-1:0]  iss_addr;
  logic           iss_ready;
  logic           flush;
  logic           err;

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [NR-1:0] re;
    logic [AW-1:0] ra0, ra1, ra2;
    logic          iv;
    logic [AW-1:0] ia;
    logic          fl;
    logic [DW-1:0] e0, e1, e2;
    logic [NR-1:0] eb;
    logic          er;
    logic          ee;
  } vec_t;

  vec_t vt[$];
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(2), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .stall(stall),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .flush(flush), .err(err)
  );

  function automatic vec_t mk(logic w, logic [AW-1:0] wa, logic [DW-1:0] wd, logic [NR-1:0] r,
                              logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2,
                              logic iv, logic [AW-1:0] ia, logic fl,
                              logic [DW-1:0] e0, logic [DW-1:0] e1, logic [DW-1:0] e2,
                              logic [NR-1:0] eb, logic er, logic ee);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.re = r; v.ra0 = a0; v.ra1 = a1; v.ra2 = a2;
    v.iv = iv; v.ia = ia; v.fl = fl; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    v.eb = eb; v.er = er; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    we = v.we; waddr = v.waddr; wdata = v.wdata; re = v.re;
    raddr = {v.ra2, v.ra1, v.ra0};
    iss_valid = v.iv; iss_addr = v.ia; flush = v.fl;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    iss_valid = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    exp_q.push_back(v.e0);
    exp_q.push_back(v.e1);
    exp_q.push_back(v.e2);
    @(negedge clk);
    for (int p = 0; p < NR; p++)
      chk($sformatf("%s rdata%0d", tag, p), rdata[p*DW +: DW], exp_q.pop_front());
    chk({tag, " rbusy"}, DW'(rbusy), DW'(v.eb));
    chk({tag, " stall"}, DW'(stall), DW'(|v.eb));
    chk({tag, " iss_ready"}, DW'(iss_ready), DW'(v.er));
    chk({tag, " err"}, DW'(err), DW'(v.ee));
  endtask

  initial begin
    vec_t v;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // post-reset sweep of r1..r31
    for (int a = 1; a < 32; a++) begin
      if (a > 1) next_drive();
      v = mk(0, 0, 0, 3'b001, AW'(a), 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0);
      drive(v);
      check_outputs($sformatf("reset_r%0d", a), v);
    end

    // bypass, zero register, scoreboard, saturation, issue/retire, flush, multi-port
    vt.push_back(mk(0, 0, 0,            3'b111, 1, 2, 3, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 5, 0, 0, 1, 5, 0, 0, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(1, 5, 32'hDEADBEEF, 3'b001, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(1, 0, 32'h12345678, 3'b011, 0, 5, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 0, 5, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 7, 0, 0, 1, 7, 0, 0, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 7, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0));
    vt.push_back(mk(1, 7, 32'hA5A5A5A5, 3'b001, 7, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 7, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 3, 0, 0, 1, 3, 0, 0, 0, 0, 3'b001, 0, 0));
    vt.push_back(mk(1, 3, 32'h1,        3'b001, 3, 0, 0, 0, 3, 0, 32'h1, 0, 0, 3'b001, 1, 0));
    vt.push_back(mk(1, 3, 32'h2,        3'b001, 3, 0, 0, 0, 3, 0, 32'h2, 0, 0, 3'b001, 1, 0));
    vt.push_back(mk(1, 3, 32'h3,        3'b001, 3, 0, 0, 0, 3, 0, 32'h3, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(1, 3, 32'h4,        3'b001, 3, 0, 0, 0, 3, 0, 32'h4, 0, 0, 3'b000, 1, 0));
    vt.push_back(mk(0, 0, 0,            3'b001, 3, 0, 0, 0, 3, 0, 32'h4, 0, 0, 3'b000, 1, 1));
    vt.push_back(mk(0, 0, 0,            3'b000, 0, 0, 0, 1, 4, 0, 0, 0, 0, 3'b000, 1, 1));
    vt.push_back(mk(1, 4, 32'h44,       3'b001, 4, 0, 0, 1, 4, 0, 32'h44, 0, 0, 3'b000, 1, 1));
    vt.push_back(mk(0, 0, 0,            3'b001, 4, 0, 0, 0, 4, 0, 32'h44, 0, 0, 3'b001, 1, 1));
    vt.push_back(mk(0, 0, 0,            3'b001, 4, 0, 0, 1, 4, 1, 32'h44, 0, 0, 3'b001, 1, 1));
    vt.push_back(mk(0, 0, 0,            3'b001, 4, 0, 0, 0, 4, 0, 32'h44, 0, 0, 3'b000, 1, 1));
    vt.push_back(mk(0, 0, 0,            3'b000, 0, 0, 0, 1, 9, 0, 0, 0, 0, 3'b000, 1, 1));
    vt.push_back(mk(1, 2, 32'h22222222, 3'b111, 2, 2, 9, 0, 0, 0, 32'h22222222, 32'h22222222, 0, 3'b100, 1, 1));
    vt.push_back(mk(1, 9, 32'h99,       3'b001, 9, 0, 0, 0, 0, 1, 32'h99, 0, 0, 3'b000, 1, 1));
    vt.push_back(mk(0, 0, 0,            3'b011, 9, 2, 0, 0, 0, 0, 32'h99, 32'h22222222, 0, 3'b000, 1, 1));

    for (int i = 0; i < vt.size(); i++) begin
      next_drive();
      drive(vt[i]);
      check_outputs($sformatf("vec%0d", i), vt[i]);
    end

    // reset mid-operation drops a pending count
    next_drive();
    drive(mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 6, 0, 0, 0, 0, 3'b000, 1, 1));
    check_outputs("mid_issue", mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 6, 0, 0, 0, 0, 3'b000, 1, 1));
    next_drive();
    rst = 1'b1;
    drive(mk(0, 0, 0, 3'b111, 6, 5, 2, 1, 6, 0, 0, 0, 0, 3'b000, 0, 0));
    check_outputs("in_reset", mk(0, 0, 0, 3'b111, 6, 5, 2, 1, 6, 0, 0, 0, 0, 3'b000, 0, 1));
    next_drive();
    rst = 1'b0;
    drive(mk(0, 0, 0, 3'b111, 6, 5, 2, 0, 6, 0, 0, 0, 0, 3'b000, 1, 0));
    check_outputs("after_reset", mk(0, 0, 0, 3'b111, 6, 5, 2, 0, 6, 0, 0, 0, 0, 3'b000, 1, 0));

    // orphan write during flush still lands and still flags err
    next_drive();
    drive(mk(1, 8, 32'h88, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 1, 0));
    check_outputs("flush_orphan", mk(1, 8, 32'h88, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 1, 0));
    next_drive();
    drive(mk(0, 0, 0, 3'b001, 8, 0, 0, 0, 0, 0, 32'h88, 0, 0, 3'b000, 1, 1));
    check_outputs("orphan_err", mk(0, 0, 0, 3'b001, 8, 0, 0, 0, 0, 0, 32'h88, 0, 0, 3'b000, 1, 1));

    next_drive();
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the two-read/one-write register file used by the 5-stage core. It is generalised to NUM_RD read ports and configurable data and address widths. It adds same-cycle write-to-read bypass and a per-register pending-write scoreboard with saturating in-flight counters, so ID can raise a hazard stall instead of relying only on EX/MEM forwarding. Sits beside decode; the writeback stage drives its write port.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports
CNT_W, 2, width of per-register in-flight counter; CNT_MAX = 2**CNT_W-1
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
we  in  1  writeback write enable; also retires one pending write
waddr  in  ADDR_W  writeback address
wdata  in  DATA_W  writeback data
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
rbusy  out  NUM_RD  port i's register has a pending write not satisfied this cycle
stall  out  1  OR of rbusy
iss_valid  in  1  ID issues an instruction that will write iss_addr
iss_addr  in  ADDR_W  destination of issued instruction
iss_ready  out  1  issue can be accepted (counter not saturated)
flush  in  1  discard all in-flight writes
err  out  1  sticky: write arrived for a register with zero pending count

Behaviour:
- Reset (rst=1 at edge): all registers 0, all counters 0, err 0. While rst=1, rdata=0, rbusy=0, stall=0, iss_ready=0.
- Reads are combinational, zero latency.
  - re[i]=0 -> rdata port i = 0.
  - ZERO_REG and raddr=0 -> 0.
  - we && waddr==raddr (and not a hardwired zero) -> wdata (bypass).
  - Otherwise -> array value.
- Write: we at edge stores wdata to waddr; ignored for address 0 when ZERO_REG.
- Counters: cnt[a] increments on an accepted issue (iss_valid && iss_ready) and decrements on we with cnt[a]>0. Same-cycle issue and retire on the same address leaves cnt unchanged. Address 0 with ZERO_REG is never counted.
- iss_ready = !rst && (cnt[iss_addr] != CNT_MAX || (we && waddr==iss_addr)). An issue while iss_ready=0 is ignored with no state change; ID must hold it.
- rbusy[i] = re[i] && eff_cnt(raddr_i) != 0, where eff_cnt = cnt minus 1 if we && waddr==raddr_i && cnt>0. A pending write retiring this cycle is satisfied by the bypass.
- stall = |rbusy.
- Orphan write: we with cnt[waddr]==0 (non-zero register) still writes the array and sets err. err clears only on rst.
- flush: at edge all counters -> 0, overriding same-cycle issue and retire. The same-cycle we still writes the array, and the err check still applies.
- Simultaneous we and read of an unrelated address: no interaction.
- Reset mid-operation: the pending count is lost. Reset must be applied to the whole pipeline together.

Decomposition:
- Shared package/defines: DATA_W and ADDR_W defaults (`RegBus`, `RegAddrBus` equivalents), ZeroWord, enable levels.
- One natural sub-module: sb_counter. A single saturating up/down counter with inc, dec, clr, cnt and nz outputs, instantiated DEPTH times by a generate loop.
- Read ports are a generate loop in the top.

Test Plan:
- Reset: rst=1 one cycle, then read r1..r31 with re=1 -> all rdata 0, rbusy 0, err 0, iss_ready 1.
- Bypass: we=1 waddr=5 wdata=0xDEADBEEF with re[0]=1 raddr0=5 same cycle -> rdata0=0xDEADBEEF; the next cycle with we=0 still reads 0xDEADBEEF. A write to r0 -> reads 0.
- Scoreboard stall: issue r7, then read r7 -> rbusy0=1, stall=1. In the cycle with we=1 waddr=7 -> rbusy0=0, rdata0=wdata, cnt returns to 0.
- Saturation (CNT_W=2): issue r3 three times -> iss_ready=0 for iss_addr=3. A fourth issue is ignored. Three writes to r3 -> rbusy clears only after the third. A fourth write sets err.
- Simultaneous issue and retire r4 with cnt=1 -> cnt stays 1, rbusy=1 next cycle. flush with issue r4 same cycle -> cnt=0, rbusy=0.
- Multi-port (NUM_RD=3): ports read r2, r2, r9, with r9 pending and the r2 write bypassed -> rdata0=rdata1=wdata, rbusy=3'b100, stall=1.
